// File: rtl/toggle_handshake_rx.sv
// -----------------------------------------------------------------------------
// toggle_handshake_rx
// Receive side of a toggle-flag handshake. The sender flips req_tgl once per
// transfer and holds req_data until it sees ack_tgl flip. This block brings
// req_tgl into the clk domain, turns each observed flip into one valid/ready
// event carrying req_data, and flips ack_tgl when the consumer takes it.
//
// Optional feature: define TOGGLE_HANDSHAKE_RX_ERR_EN to enable the sticky
// protocol error flag (sender flipped again while an event was still pending).
// Without it err is tied to 0.
//
// Parameters:
//   SYNC_STAGES  synchroniser depth on req_tgl (legal 2..4)
//   DATA_W       data word width
//   CNT_W        saturating consumed-event counter width
// Ports:
//   clk, rst_n   receive clock, async active-low reset
//   req_tgl      request toggle from sender (asynchronous to clk)
//   req_data     sender data, stable from req_tgl flip until ack_tgl flip
//   ack_tgl      acknowledge toggle back to sender (registered)
//   evt_valid    event pending for local consumer
//   evt_data     captured data, held while evt_valid
//   evt_ready    consumer accepts event
//   evt_cnt      number of consumed events, saturating
//   busy         same as evt_valid
//   err          sticky protocol error
// -----------------------------------------------------------------------------
module toggle_handshake_rx #(
   parameter int SYNC_STAGES = 2,
   parameter int DATA_W      = 8,
   parameter int CNT_W       = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_tgl,
   input  logic [DATA_W-1:0] req_data,
   output logic              ack_tgl,
   output logic              evt_valid,
   output logic [DATA_W-1:0] evt_data,
   input  logic              evt_ready,
   output logic [CNT_W-1:0]  evt_cnt,
   output logic              busy,
   output logic              err
);

   typedef enum logic {S_IDLE = 1'b0, S_PEND = 1'b1} state_t;

   state_t                 r_state, w_state_nxt;
   logic [SYNC_STAGES-1:0] r_sync;
   logic                   r_req_seen;
   logic                   r_ack;
   logic [DATA_W-1:0]      r_data;
   logic [CNT_W-1:0]       r_cnt;
   logic                   w_req_s;
   logic                   w_capture;
   logic                   w_consume;

   // Only the last synchroniser stage is looked at by any logic.
   assign w_req_s = r_sync[SYNC_STAGES-1];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_sync <= '0;
      else        r_sync <= {r_sync[SYNC_STAGES-2:0], req_tgl};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_state_nxt;
   end

   // Capture only from IDLE and consume only from PEND, so the two can never
   // coincide on one edge.
   always_comb begin
      w_state_nxt = r_state;
      w_capture   = 1'b0;
      w_consume   = 1'b0;
      case (r_state)
         S_IDLE: if (w_req_s != r_req_seen) begin
            w_capture   = 1'b1;
            w_state_nxt = S_PEND;
         end
         S_PEND: if (evt_ready) begin
            w_consume   = 1'b1;
            w_state_nxt = S_IDLE;
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // req_data is sampled directly: the sender holds it stable from its flip
   // until our ack flip, and the flip is seen here only after synchronising.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_req_seen <= 1'b0;
         r_data     <= '0;
      end else if (w_capture) begin
         r_req_seen <= w_req_s;
         r_data     <= req_data;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ack <= 1'b0;
         r_cnt <= '0;
      end else if (w_consume) begin
         r_ack <= ~r_ack;
         if (r_cnt != {CNT_W{1'b1}}) r_cnt <= r_cnt + CNT_W'(1);
      end
   end

`ifdef TOGGLE_HANDSHAKE_RX_ERR_EN
   // A second flip while pending is flagged but not dropped: req_seen still
   // differs after consumption, so it is captured again from IDLE.
   logic r_err;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                        r_err <= 1'b0;
      else if (r_state == S_PEND && w_req_s != r_req_seen) r_err <= 1'b1;
   end
   assign err = r_err;
`else
   assign err = 1'b0;
`endif

   assign ack_tgl   = r_ack;
   assign evt_valid = (r_state == S_PEND);
   assign busy      = evt_valid;
   assign evt_data  = r_data;
   assign evt_cnt   = r_cnt;

endmodule
